// File: rtl/sprite_blit_master_if.sv
// rtl/sprite_blit_master_if.sv - shared Avalon-MM memory port between the blitter and on-chip RAM
interface sprite_blit_master_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          mem_grant;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport master (
    input  mem_grant, readdata,
    output address, chipselect, write, writedata
  );

  modport slave (
    output mem_grant, readdata,
    input  address, chipselect, write, writedata
  );
endinterface

// File: rtl/sprite_blit_master.sv
// rtl/sprite_blit_master.sv - rectangular byte blitter over a granted Avalon-MM memory port
// Optional colour-key skip enabled by defining BLIT_TRANSPARENCY_EN.
module sprite_blit_master #(
  parameter int AW = 19,
  parameter int DW = 8,
  parameter int NW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [NW-1:0] width,
  input  logic [NW-1:0] height,
  input  logic [NW-1:0] src_stride,
  input  logic [NW-1:0] dst_stride,
  input  logic [DW-1:0] key_color,
  output logic          busy,
  output logic          done,
  sprite_blit_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t        state;
  logic [NW-1:0] w_r, h_r, ss_r, ds_r;
  logic [NW-1:0] x, y;
  logic [AW-1:0] src_row, dst_row;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wd_r;
  logic          skip;

`ifdef BLIT_TRANSPARENCY_EN
  logic [DW-1:0] key_r;
  assign skip = (bus.readdata == key_r);
`else
  logic unused_key;
  assign unused_key = ^key_color;
  assign skip = 1'b0;
`endif

  logic          x_last, y_last, advance;
  logic [AW-1:0] x_ext, src_row_nx, dst_row_nx, adv_addr;

  assign x_last     = (x == w_r - 1'b1);
  assign y_last     = (y == h_r - 1'b1);
  assign x_ext      = {{(AW-NW){1'b0}}, x};
  assign src_row_nx = src_row + {{(AW-NW){1'b0}}, ss_r};
  assign dst_row_nx = dst_row + {{(AW-NW){1'b0}}, ds_r};
  assign adv_addr   = x_last ? src_row_nx : (src_row + x_ext + 1'b1);
  assign advance    = ((state == CAP) && skip) || ((state == WR) && bus.mem_grant);

  // Strobes follow the grant combinationally so a denied cycle never reaches the slave.
  assign bus.chipselect = ((state == RD) || (state == WR)) && bus.mem_grant;
  assign bus.write      = (state == WR) && bus.mem_grant;
  assign bus.address    = addr_r;
  assign bus.writedata  = wd_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr_r  <= '0;
      wd_r    <= '0;
      w_r     <= '0;
      h_r     <= '0;
      ss_r    <= '0;
      ds_r    <= '0;
      x       <= '0;
      y       <= '0;
      src_row <= '0;
      dst_row <= '0;
`ifdef BLIT_TRANSPARENCY_EN
      key_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          w_r     <= width;
          h_r     <= height;
          ss_r    <= src_stride;
          ds_r    <= dst_stride;
`ifdef BLIT_TRANSPARENCY_EN
          key_r   <= key_color;
`endif
          x       <= '0;
          y       <= '0;
          src_row <= src_base;
          dst_row <= dst_base;
          addr_r  <= src_base;
          if (width == '0 || height == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state <= RD;
            busy  <= 1'b1;
          end
        end
        RD: if (bus.mem_grant) state <= CAP;
        CAP: if (!skip) begin
          state  <= WR;
          addr_r <= dst_row + x_ext;
          wd_r   <= bus.readdata;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase

      // Shared pixel/row stepping for both the skip path out of CAP and a granted write.
      if (advance) begin
        if (!x_last) begin
          x <= x + 1'b1;
        end else begin
          x <= '0;
          if (!y_last) begin
            y       <= y + 1'b1;
            src_row <= src_row_nx;
            dst_row <= dst_row_nx;
          end
        end
        if (x_last && y_last) begin
          state <= FIN;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state  <= RD;
          addr_r <= adv_addr;
        end
      end
    end
  end
endmodule
